chanels_serializer: RTL and testbench

CHANELS_SERIALIZER -- requirements
Module: chanels_serializer

---
 rtl/chanels_serializer_if.sv | 28 ++
 rtl/chanels_serializer.sv | 96 +++++++++
 tb/tb_chanels_serializer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chanels_serializer_if.sv
// Per-channel sample strobes/data and the serialized output bundle of chanels_serializer.
interface chanels_serializer_if #(
  parameter int CHANELS = 4,
  parameter int WIDTH   = 32
);
  localparam int AW = $clog2(CHANELS);

  logic [CHANELS-1:0]            i_vld;
  logic [CHANELS-1:0][WIDTH-1:0] i_ac;
  logic [CHANELS-1:0][WIDTH-1:0] i_ph;
  logic                          i_ovf_clr;
  logic                          o_vld;
  logic [AW-1:0]                 o_addres;
  logic [WIDTH-1:0]              o_ac;
  logic [WIDTH-1:0]              o_ph;
  logic [CHANELS-1:0]            o_ovf;
  logic [CHANELS-1:0]            o_pend;

  modport master (
    output i_vld, i_ac, i_ph, i_ovf_clr,
    input  o_vld, o_addres, o_ac, o_ph, o_ovf, o_pend
  );

  modport slave (
    input  i_vld, i_ac, i_ph, i_ovf_clr,
    output o_vld, o_addres, o_ac, o_ph, o_ovf, o_pend
  );
endinterface

// File: rtl/chanels_serializer.sv
// Round-robin serializer: one 1-deep holding register per channel, one output sample per cycle.
module chanels_serializer #(
  parameter int CHANELS = 4,
  parameter int WIDTH   = 32
) (
  input logic                 clk,
  input logic                 rstn,
  chanels_serializer_if.slave bus
);
  localparam int AW = $clog2(CHANELS);
  localparam logic [AW-1:0] LAST = AW'(CHANELS - 1);

  logic [CHANELS-1:0]            pend_q, pend_d;
  logic [CHANELS-1:0]            ovf_q, ovf_d;
  logic [CHANELS-1:0][WIDTH-1:0] hac_q, hac_d;
  logic [CHANELS-1:0][WIDTH-1:0] hph_q, hph_d;
  logic [AW-1:0]                 rr_q, rr_d;
  logic                          ovld_q;
  logic [AW-1:0]                 oaddr_q;
  logic [WIDTH-1:0]              oac_q, oph_q;
  logic                          gnt_vld;
  logic [AW-1:0]                 gnt_idx;

  // Search starts at rr_q and wraps at CHANELS, so non-power-of-two counts never visit unused slots.
  always_comb begin : arb
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < CHANELS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= unsigned'(CHANELS)) idx = idx - unsigned'(CHANELS);
      if (!gnt_vld && pend_q[AW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = AW'(idx);
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = bus.i_ovf_clr ? '0 : ovf_q;
    hac_d  = hac_q;
    hph_d  = hph_q;
    rr_d   = rr_q;
    if (gnt_vld) begin
      pend_d[gnt_idx] = 1'b0;
      rr_d            = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
    // A granted channel frees its slot this edge, so a same-cycle strobe refills it instead of overflowing.
    for (int unsigned k = 0; k < CHANELS; k++) begin
      if (bus.i_vld[k]) begin
        if (!pend_q[k] || (gnt_vld && gnt_idx == AW'(k))) begin
          pend_d[k] = 1'b1;
          hac_d[k]  = bus.i_ac[k];
          hph_d[k]  = bus.i_ph[k];
        end else begin
          ovf_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q  <= '0;
      ovf_q   <= '0;
      hac_q   <= '0;
      hph_q   <= '0;
      rr_q    <= '0;
      ovld_q  <= 1'b0;
      oaddr_q <= '0;
      oac_q   <= '0;
      oph_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      hac_q  <= hac_d;
      hph_q  <= hph_d;
      rr_q   <= rr_d;
      ovld_q <= gnt_vld;
      if (gnt_vld) begin
        oaddr_q <= gnt_idx;
        oac_q   <= hac_q[gnt_idx];
        oph_q   <= hph_q[gnt_idx];
      end
    end
  end

  assign bus.o_vld    = ovld_q;
  assign bus.o_addres = oaddr_q;
  assign bus.o_ac     = oac_q;
  assign bus.o_ph     = oph_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_pend   = pend_q;
endmodule

// File: tb/tb_chanels_serializer.sv
// Bench for chanels_serializer: a 4-channel and a 3-channel instance against a cycle-level reference model.
module tb_chanels_serializer;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  chanels_serializer_if #(.CHANELS(4), .WIDTH(32)) b4 ();
  chanels_serializer_if #(.CHANELS(3), .WIDTH(32)) b3 ();

  chanels_serializer #(.CHANELS(4), .WIDTH(32)) dut4 (.clk(clk), .rstn(rstn), .bus(b4));
  chanels_serializer #(.CHANELS(3), .WIDTH(32)) dut3 (.clk(clk), .rstn(rstn), .bus(b3));

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus per unit: 0 -> 4-channel instance, 1 -> 3-channel instance
  logic [3:0]  in_vld [2];
  logic [31:0] in_ac  [2][4];
  logic [31:0] in_ph  [2][4];
  logic        in_clr [2];

  // reference model state
  logic [3:0]  m_pend [2];
  logic [31:0] m_hac  [2][4];
  logic [31:0] m_hph  [2][4];
  int          m_rr   [2];
  logic [3:0]  m_ovf  [2];
  logic        m_ovld [2];
  int          m_oaddr[2];
  logic [31:0] m_oac  [2];
  logic [31:0] m_oph  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    b4.i_vld     = in_vld[0];
    b4.i_ovf_clr = in_clr[0];
    b3.i_vld     = in_vld[1][2:0];
    b3.i_ovf_clr = in_clr[1];
    for (int k = 0; k < 4; k++) begin
      b4.i_ac[k] = in_ac[0][k];
      b4.i_ph[k] = in_ph[0][k];
    end
    for (int k = 0; k < 3; k++) begin
      b3.i_ac[k] = in_ac[1][k];
      b3.i_ph[k] = in_ph[1][k];
    end
  endtask

  task automatic clear_in();
    for (int u = 0; u < 2; u++) begin
      in_vld[u] = '0;
      in_clr[u] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        in_ac[u][k] = '0;
        in_ph[u][k] = '0;
      end
    end
  endtask

  task automatic fill_rand();
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 4; k++) begin
        in_ac[u][k] = $urandom();
        in_ph[u][k] = $urandom();
      end
  endtask

  task automatic mreset();
    for (int u = 0; u < 2; u++) begin
      m_pend[u]  = '0;
      m_ovf[u]   = '0;
      m_rr[u]    = 0;
      m_ovld[u]  = 1'b0;
      m_oaddr[u] = 0;
      m_oac[u]   = '0;
      m_oph[u]   = '0;
      for (int k = 0; k < 4; k++) begin
        m_hac[u][k] = '0;
        m_hph[u][k] = '0;
      end
    end
  endtask

  // one rising edge of unit u, from the behavioural rules
  task automatic mstep(input int u);
    int n;
    int g;
    int c;
    logic [3:0] was;
    n   = (u == 0) ? 4 : 3;
    g   = -1;
    was = m_pend[u];
    for (int i = 0; i < n; i++) begin
      c = (m_rr[u] + i) % n;
      if (g < 0 && was[c]) g = c;
    end
    if (in_clr[u]) m_ovf[u] = '0;
    m_ovld[u] = (g >= 0);
    if (g >= 0) begin
      m_oaddr[u]   = g;
      m_oac[u]     = m_hac[u][g];
      m_oph[u]     = m_hph[u][g];
      m_rr[u]      = (g + 1) % n;
      m_pend[u][g] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (in_vld[u][k]) begin
        if (!was[k] || k == g) begin
          m_hac[u][k]  = in_ac[u][k];
          m_hph[u][k]  = in_ph[u][k];
          m_pend[u][k] = 1'b1;
        end else begin
          m_ovf[u][k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp4();
    chk("u4_vld",  64'(b4.o_vld),    64'(m_ovld[0]));
    chk("u4_addr", 64'(b4.o_addres), 64'(m_oaddr[0]));
    chk("u4_ac",   64'(b4.o_ac),     64'(m_oac[0]));
    chk("u4_ph",   64'(b4.o_ph),     64'(m_oph[0]));
    chk("u4_ovf",  64'(b4.o_ovf),    64'(m_ovf[0]));
    chk("u4_pend", 64'(b4.o_pend),   64'(m_pend[0]));
  endtask

  task automatic cmp3();
    chk("u3_vld",  64'(b3.o_vld),    64'(m_ovld[1]));
    chk("u3_addr", 64'(b3.o_addres), 64'(m_oaddr[1]));
    chk("u3_ac",   64'(b3.o_ac),     64'(m_oac[1]));
    chk("u3_ph",   64'(b3.o_ph),     64'(m_oph[1]));
    chk("u3_ovf",  64'(b3.o_ovf),    64'(m_ovf[1][2:0]));
    chk("u3_pend", 64'(b3.o_pend),   64'(m_pend[1][2:0]));
  endtask

  task automatic cycle();
    apply();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    cmp4();
    cmp3();
  endtask

  // reset asserted mid-cycle, held across one edge, released mid-cycle
  task automatic async_reset();
    #2;
    rstn = 1'b0;
    mreset();
    #1;
    chk("rst_vld",  64'(b4.o_vld),    64'd0);
    chk("rst_addr", 64'(b4.o_addres), 64'd0);
    chk("rst_ac",   64'(b4.o_ac),     64'd0);
    chk("rst_ph",   64'(b4.o_ph),     64'd0);
    chk("rst_ovf",  64'(b4.o_ovf),    64'd0);
    chk("rst_pend", 64'(b4.o_pend),   64'd0);
    cmp3();
    @(posedge clk);
    #3;
    rstn = 1'b1;
    cmp4();
    cmp3();
  endtask

  initial begin
    rstn = 1'b0;
    clear_in();
    apply();
    mreset();
    @(posedge clk);
    #1;
    cmp4();
    cmp3();
    #2;
    rstn = 1'b1;

    // single strobe on channel 2: one output two edges later
    in_vld[0]   = 4'b0100;
    in_ac[0][2] = 32'h0000_0011;
    in_ph[0][2] = 32'hFFFF_FFF0;
    cycle();
    chk("r32_pend", 64'(b4.o_pend), 64'b0100);
    clear_in();
    cycle();
    chk("r32_vld",  64'(b4.o_vld),    64'd1);
    chk("r32_addr", 64'(b4.o_addres), 64'd2);
    chk("r32_ac",   64'(b4.o_ac),     64'h11);
    chk("r32_ph",   64'(b4.o_ph),     64'hFFFF_FFF0);
    cycle();
    chk("r32_once", 64'(b4.o_vld), 64'd0);

    // all four strobed once right after reset
    async_reset();
    in_vld[0] = 4'hF;
    fill_rand();
    cycle();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("r33_vld",  64'(b4.o_vld),    64'd1);
      chk("r33_addr", 64'(b4.o_addres), 64'(i));
    end
    chk("r33_pend", 64'(b4.o_pend), 64'd0);

    // channel 1 strobed while still holding a sample -> drop and sticky flag
    for (int i = 0; i < 3; i++) begin
      in_vld[0] = 4'hF;
      fill_rand();
      cycle();
    end
    clear_in();
    for (int i = 0; i < 6; i++) cycle();
    chk("r34_ovf1", 64'(b4.o_ovf[1]), 64'd1);
    in_clr[0] = 1'b1;
    cycle();
    in_clr[0] = 1'b0;
    chk("r34_clr", 64'(b4.o_ovf), 64'd0);

    // reset while channels 1 and 3 hold samples
    in_vld[0] = 4'b1010;
    fill_rand();
    cycle();
    clear_in();
    chk("r36_pend", 64'(b4.o_pend), 64'b1010);
    async_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("r36_novld", 64'(b4.o_vld), 64'd0);
    end

    // clear and a fresh overflow on the same edge: the overflow wins for its bit
    in_vld[0] = 4'b0011;
    fill_rand();
    cycle();
    in_vld[0] = 4'b0010;
    in_clr[0] = 1'b1;
    cycle();
    clear_in();
    chk("clr_vs_set", 64'(b4.o_ovf), 64'b0010);
    for (int i = 0; i < 3; i++) cycle();

    // 3-channel instance: rotating strobes, grants wrap 2 -> 0 with no overflow
    async_reset();
    for (int i = 0; i < 12; i++) begin
      in_vld[1] = 4'(1 << (i % 3));
      fill_rand();
      cycle();
      if (i == 0) chk("r31_first", 64'(b3.o_pend), 64'b001);
      if (i > 0) begin
        chk("r35_vld",  64'(b3.o_vld),    64'd1);
        chk("r35_addr", 64'(b3.o_addres), 64'((i - 1) % 3));
      end
    end
    clear_in();
    cycle();
    chk("r35_last", 64'(b3.o_addres), 64'd2);
    chk("r35_ovf",  64'(b3.o_ovf),    64'd0);

    // randomized traffic on both instances, one reset in the middle
    for (int i = 0; i < 300; i++) begin
      for (int u = 0; u < 2; u++) begin
        in_vld[u] = 4'($urandom() & $urandom());
        in_clr[u] = ($urandom_range(0, 15) == 0);
      end
      fill_rand();
      cycle();
      if (i == 150) async_reset();
    end
    clear_in();
    for (int i = 0; i < 6; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
